// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 responder (CPOL=0, CPHA=0), MSB first, active-low select.
// SPI_CLK, SPI_EN and SPI_MOSI are asynchronous and are oversampled on clk.
// Received bytes leave on rx_data with a one-clk rx_valid pulse. Transmit bytes come
// from a one-deep buffer loaded through tx_load/tx_ready.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   SPI_CLK, SPI_EN   serial clock (idles low) and active-low select from the initiator
//   SPI_MOSI          serial data in
//   SPI_MISO          serial data out (registered)
//   tx_data, tx_load  transmit byte and load strobe (honoured only while tx_ready=1)
//   tx_ready          transmit buffer empty
//   rx_data, rx_valid last complete received byte and its update pulse
//   busy              high in LOAD and SHIFT
//   tx_underrun       pulse when DEFAULT_TX is substituted for an empty buffer
//   rx_abort          (only with SPI_PERIPHERAL_ABORT_FLAG_EN) pulse when select rises
//                     mid-byte
//
// Optional feature macro: SPI_PERIPHERAL_ABORT_FLAG_EN.
module spi_peripheral #(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_CLK,
  input  logic                  SPI_EN,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
`ifdef SPI_PERIPHERAL_ABORT_FLAG_EN
  ,
  output logic                  rx_abort
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  // Synchronizers plus one extra flop on clock and select for edge detection.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_d, r_ss_d;

  state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]  r_rx_shift, w_rx_shift_nxt;
  logic [DATA_WIDTH-1:0]  r_rx_data, w_rx_data_nxt;
  logic                   r_rx_valid, w_rx_valid_nxt;
  logic [DATA_WIDTH-1:0]  r_tx_shift, w_tx_shift_nxt;
  logic [DATA_WIDTH-1:0]  r_tx_next, w_tx_next_nxt;
  logic [DATA_WIDTH-1:0]  r_buf, w_buf_nxt;
  logic                   r_buf_full, w_buf_full_nxt;
  logic                   r_miso, w_miso_nxt;
  logic                   r_underrun, w_underrun_nxt;
  logic                   r_abort, w_abort_nxt;

  logic w_sclk, w_ss, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_next_nxt  = r_tx_next;
    w_buf_nxt      = r_buf;
    w_buf_full_nxt = r_buf_full;
    w_miso_nxt     = r_miso;
    w_underrun_nxt = 1'b0;
    w_abort_nxt    = 1'b0;

    // Loads only ever land in an empty buffer; consumption below only touches a full one,
    // so the two never collide.
    if (tx_load && !r_buf_full) begin
      w_buf_nxt      = tx_data;
      w_buf_full_nxt = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        w_miso_nxt    = 1'b0;
        w_bit_cnt_nxt = '0;
        if (w_ss_fall) w_state_nxt = StLoad;
      end
      StLoad: begin
        if (r_buf_full) begin
          w_tx_shift_nxt = r_buf;
          w_buf_full_nxt = 1'b0;
        end else begin
          w_tx_shift_nxt = DEFAULT_TX;
          w_underrun_nxt = 1'b1;
        end
        w_miso_nxt  = w_tx_shift_nxt[DATA_WIDTH-1];
        w_state_nxt = StShift;
      end
      StShift: begin
        if (w_ss_rise) begin
          w_abort_nxt   = (r_bit_cnt != '0);
          w_bit_cnt_nxt = '0;
          w_miso_nxt    = 1'b0;
          w_state_nxt   = StIdle;
        end else if (w_sclk_rise) begin
          w_rx_shift_nxt = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
          if (r_bit_cnt == LAST_BIT) begin
            w_rx_data_nxt  = w_rx_shift_nxt;
            w_rx_valid_nxt = 1'b1;
            w_bit_cnt_nxt  = '0;
            // Prefetch the next byte now so it is ready at the following falling edge.
            if (r_buf_full) begin
              w_tx_next_nxt  = r_buf;
              w_buf_full_nxt = 1'b0;
            end else begin
              w_tx_next_nxt  = DEFAULT_TX;
              w_underrun_nxt = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_bit_cnt == '0) w_tx_shift_nxt = r_tx_next;
          else                 w_tx_shift_nxt = r_tx_shift << 1;
          w_miso_nxt = w_tx_shift_nxt[DATA_WIDTH-1];
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;  // select idles high; avoids a false ss_fall out of reset
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
      r_state     <= StIdle;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_shift  <= '0;
      r_tx_next   <= '0;
      r_buf       <= '0;
      r_buf_full  <= 1'b0;
      r_miso      <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_EN};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx_next   <= w_tx_next_nxt;
      r_buf       <= w_buf_nxt;
      r_buf_full  <= w_buf_full_nxt;
      r_miso      <= w_miso_nxt;
      r_underrun  <= w_underrun_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  assign SPI_MISO    = r_miso;
  assign tx_ready    = ~r_buf_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = (r_state != StIdle);
  assign tx_underrun = r_underrun;

`ifdef SPI_PERIPHERAL_ABORT_FLAG_EN
  assign rx_abort = r_abort;
`else
  logic w_abort_unused;
  assign w_abort_unused = r_abort;
`endif

endmodule
